excess3_bcd_seq_conv: RTL and testbench

//  Converts a DIGITS-wide packed Excess-3 word into packed BCD, one digit per clock, digit 0 (LSN) first.

---
 rtl/excess3_pkg.sv | 14 +
 rtl/excess3_digit_conv.sv | 16 +
 rtl/excess3_bcd_seq_conv.sv | 127 ++++++++++++
 tb/tb_excess3_bcd_seq_conv.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/excess3_pkg.sv
// Shared constants and FSM state type for the Excess-3 to BCD sequential converter.
package excess3_pkg;

  localparam logic [3:0] XS3_OFFSET = 4'd3;
  localparam logic [3:0] XS3_MIN    = 4'd3;
  localparam logic [3:0] XS3_MAX    = 4'd12;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CONV,
    S_DONE
  } state_e;

endpackage

// File: rtl/excess3_digit_conv.sv
// Combinational single-digit Excess-3 to BCD converter with invalid-code flag.
module excess3_digit_conv
  import excess3_pkg::*;
(
  input  logic [3:0] xs3_i,
  output logic [3:0] bcd_o,
  output logic       invalid_o
);

  // Codes outside 3..12 map to zero and raise the invalid flag.
  always_comb begin
    invalid_o = (xs3_i < XS3_MIN) || (xs3_i > XS3_MAX);
    bcd_o     = invalid_o ? 4'd0 : (xs3_i - XS3_OFFSET);
  end

endmodule

// File: rtl/excess3_bcd_seq_conv.sv
// Sequential Excess-3 to BCD word converter: one digit per clock, digit 0 first,
// valid/ready on both sides. Define XS3_ERRCNT_EN to add the saturating err_cnt port.
module excess3_bcd_seq_conv
  import excess3_pkg::*;
#(
  parameter int unsigned DIGITS    = 4,
  parameter int unsigned ERR_CNT_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4*DIGITS-1:0]   in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   out_data,
  output logic [DIGITS-1:0]     out_err_mask,
  output logic                  out_err
`ifdef XS3_ERRCNT_EN
  ,
  output logic [ERR_CNT_W-1:0]  err_cnt
`endif
);

  localparam int unsigned CntW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(DIGITS - 1);

  state_e              state_q;
  logic [CntW-1:0]     cnt_q;
  logic [4*DIGITS-1:0] data_q;
  logic [4*DIGITS-1:0] result_q;
  logic [DIGITS-1:0]   mask_q;
  logic                out_valid_q;

  logic [3:0]          cur_xs3;
  logic [3:0]          cur_bcd;
  logic                cur_invalid;

  // Select the digit currently being converted.
  always_comb begin
    cur_xs3 = data_q[{cnt_q, 2'b00} +: 4];
  end

  excess3_digit_conv u_digit_conv (
    .xs3_i     (cur_xs3),
    .bcd_o     (cur_bcd),
    .invalid_o (cur_invalid)
  );

  // Ready in IDLE, or in DONE when the held word leaves this cycle (back-to-back accept).
  always_comb begin
    in_ready = (state_q == S_IDLE) || ((state_q == S_DONE) && out_ready);
  end

  // Conversion FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      data_q      <= '0;
      result_q    <= '0;
      mask_q      <= '0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            data_q   <= in_data;
            result_q <= '0;
            mask_q   <= '0;
            cnt_q    <= '0;
            state_q  <= S_CONV;
          end
        end
        S_CONV: begin
          result_q[{cnt_q, 2'b00} +: 4] <= cur_bcd;
          mask_q[cnt_q]                 <= cur_invalid;
          if (cnt_q == LastCnt) begin
            state_q     <= S_DONE;
            out_valid_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            if (in_valid) begin
              data_q   <= in_data;
              result_q <= '0;
              mask_q   <= '0;
              cnt_q    <= '0;
              state_q  <= S_CONV;
            end else begin
              state_q <= S_IDLE;
            end
          end
        end
        default: begin
          state_q     <= S_IDLE;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign out_valid    = out_valid_q;
  assign out_data     = result_q;
  assign out_err_mask = mask_q;
  assign out_err      = |mask_q;

`ifdef XS3_ERRCNT_EN
  logic [ERR_CNT_W-1:0] err_cnt_q;

  // Count delivered words carrying any invalid digit; hold at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt_q <= '0;
    end else if (out_valid_q && out_ready && out_err && (err_cnt_q != '1)) begin
      err_cnt_q <= err_cnt_q + ERR_CNT_W'(1);
    end
  end

  assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_excess3_bcd_seq_conv.sv
// Directed bench for excess3_bcd_seq_conv: a DIGITS=4 instance and a DIGITS=1 instance.
// Build with XS3_ERRCNT_EN defined to also exercise err_cnt.
module tb_excess3_bcd_seq_conv;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready, out_err;
  logic [15:0] in_data, out_data;
  logic [3:0]  out_err_mask;
`ifdef XS3_ERRCNT_EN
  logic [7:0]  err_cnt;
  logic [7:0]  d1_err_cnt;
`endif

  logic        d1_in_valid, d1_in_ready, d1_out_valid, d1_out_err;
  logic [3:0]  d1_in_data, d1_out_data;
  logic [0:0]  d1_mask;

  excess3_bcd_seq_conv #(.DIGITS(4), .ERR_CNT_W(8)) dut4 (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_err_mask (out_err_mask),
    .out_err      (out_err)
`ifdef XS3_ERRCNT_EN
    ,
    .err_cnt      (err_cnt)
`endif
  );

  excess3_bcd_seq_conv #(.DIGITS(1), .ERR_CNT_W(8)) dut1 (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (d1_in_valid),
    .in_ready     (d1_in_ready),
    .in_data      (d1_in_data),
    .out_valid    (d1_out_valid),
    .out_ready    (1'b1),
    .out_data     (d1_out_data),
    .out_err_mask (d1_mask),
    .out_err      (d1_out_err)
`ifdef XS3_ERRCNT_EN
    ,
    .err_cnt      (d1_err_cnt)
`endif
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a word until accepted (bounded), then drop in_valid and drive junk.
  task automatic send(input logic [15:0] w);
    in_valid = 1'b1;
    in_data  = w;
    #1;
    for (int i = 0; i < 50 && !in_ready; i++) tick();
    check("send_ready", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    in_data  = 16'hFFFF;
  endtask

  task automatic wait_out();
    for (int i = 0; i < 20 && !out_valid; i++) tick();
    check("out_valid_timeout", {31'd0, out_valid}, 32'd1);
  endtask

  logic [3:0]  exp_bcd [16];
  logic [15:0] exp_err;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_bcd = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd1, 4'd2, 4'd3, 4'd4,
                4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd0, 4'd0, 4'd0};
    exp_err = 16'b1110_0000_0000_0111;

    rst         = 1'b1;
    in_valid    = 1'b0;
    in_data     = 16'h0000;
    out_ready   = 1'b1;
    d1_in_valid = 1'b0;
    d1_in_data  = 4'h0;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_data", {16'd0, out_data}, 32'h0);
    check("rst_mask", {28'd0, out_err_mask}, 32'h0);
    check("rst_out_err", {31'd0, out_err}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
`ifdef XS3_ERRCNT_EN
    check("rst_err_cnt", {24'd0, err_cnt}, 32'd0);
`endif

    // 1: basic conversion and exact latency
    send(16'h3C48);
    tick(); tick(); tick();
    check("t1_lat_early", {31'd0, out_valid}, 32'd0);
    tick();
    check("t1_lat_on", {31'd0, out_valid}, 32'd1);
    check("t1_data", {16'd0, out_data}, 32'h0915);
    check("t1_mask", {28'd0, out_err_mask}, 32'h0);
    check("t1_err", {31'd0, out_err}, 32'd0);
    tick();
    check("t1_valid_drop", {31'd0, out_valid}, 32'd0);
    check("t1_idle_ready", {31'd0, in_ready}, 32'd1);
    check("t1_data_hold", {16'd0, out_data}, 32'h0915);

    // 2: invalid digit
    send(16'h3F43);
    wait_out();
    check("t2_data", {16'd0, out_data}, 32'h0010);
    check("t2_mask", {28'd0, out_err_mask}, 32'h4);
    check("t2_err", {31'd0, out_err}, 32'd1);
`ifdef XS3_ERRCNT_EN
    check("t2_cnt_before", {24'd0, err_cnt}, 32'd0);
`endif
    tick();
`ifdef XS3_ERRCNT_EN
    check("t2_cnt_after", {24'd0, err_cnt}, 32'd1);
`endif

    // 3: backpressure, then same-edge output/input handshake
    out_ready = 1'b0;
    send(16'h5678);
    wait_out();
    check("t3_data", {16'd0, out_data}, 32'h2345);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("t3_hold_valid", {31'd0, out_valid}, 32'd1);
      check("t3_hold_data", {16'd0, out_data}, 32'h2345);
      check("t3_hold_ready", {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 16'h4444;
    #1;
    check("t3_same_edge_ready", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    in_data  = 16'hFFFF;
    check("t3_valid_drop", {31'd0, out_valid}, 32'd0);
    check("t3_conv_busy", {31'd0, in_ready}, 32'd0);
    tick(); tick(); tick();
    check("t3_lat_early", {31'd0, out_valid}, 32'd0);
    tick();
    check("t3_lat_on", {31'd0, out_valid}, 32'd1);
    check("t3_data2", {16'd0, out_data}, 32'h1111);
    tick();

    // 4: reset mid-conversion discards the word
    send(16'hCCCC);
    tick(); tick();
    rst = 1'b1;
    tick();
    check("t4_rst_valid", {31'd0, out_valid}, 32'd0);
    check("t4_rst_ready", {31'd0, in_ready}, 32'd1);
    check("t4_rst_data", {16'd0, out_data}, 32'h0);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    check("t4_no_output", {31'd0, out_valid}, 32'd0);
    send(16'hCCCC);
    wait_out();
    check("t4_data", {16'd0, out_data}, 32'h9999);
    check("t4_err", {31'd0, out_err}, 32'd0);

    // 5: stream of all-invalid words, counter saturation
    for (int w = 0; w < 300; w++) begin
      send(16'h0000);
      wait_out();
      check("t5_mask", {28'd0, out_err_mask}, 32'hF);
`ifdef XS3_ERRCNT_EN
      if (w == 100) check("t5_cnt_mid", {24'd0, err_cnt}, 32'd100);
`endif
    end
    tick();
    check("t5_end_valid", {31'd0, out_valid}, 32'd0);
`ifdef XS3_ERRCNT_EN
    check("t5_cnt_sat", {24'd0, err_cnt}, 32'd255);
`endif

    // 6: DIGITS=1 instance
    d1_in_valid = 1'b1;
    d1_in_data  = 4'h7;
    #1;
    check("t6_ready", {31'd0, d1_in_ready}, 32'd1);
    tick();
    d1_in_valid = 1'b0;
    check("t6_conv_valid", {31'd0, d1_out_valid}, 32'd0);
    tick();
    check("t6_valid7", {31'd0, d1_out_valid}, 32'd1);
    check("t6_data7", {28'd0, d1_out_data}, 32'h4);
    check("t6_err7", {31'd0, d1_out_err}, 32'd0);
    tick();
    d1_in_valid = 1'b1;
    d1_in_data  = 4'h2;
    tick();
    d1_in_valid = 1'b0;
    tick();
    check("t6_data2", {28'd0, d1_out_data}, 32'h0);
    check("t6_err2", {31'd0, d1_out_err}, 32'd1);
    tick();
    for (int c = 0; c < 16; c++) begin
      d1_in_valid = 1'b1;
      d1_in_data  = 4'(c);
      #1;
      for (int i = 0; i < 10 && !d1_in_ready; i++) tick();
      tick();
      d1_in_valid = 1'b0;
      tick();
      check("t6_sweep_valid", {31'd0, d1_out_valid}, 32'd1);
      check("t6_sweep_data", {28'd0, d1_out_data}, {28'd0, exp_bcd[c]});
      check("t6_sweep_err", {31'd0, d1_out_err}, {31'd0, exp_err[c]});
      check("t6_sweep_mask", {31'd0, d1_mask}, {31'd0, exp_err[c]});
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
